// File: rtl/pid_fan_pwm.sv
// rtl/pid_fan_pwm.sv - PID-driven fan PWM with OFF/KICK/RUN start-up control
// Optional feature macro: PWM_MIN_DUTY_EN (raise small nonzero duty to MIN_DUTY).
module pid_fan_pwm #(
    parameter int ADC_BITWIDTH = 8,
    parameter int PRESCALER    = 4,
    parameter int KICK_PERIODS = 16,
    parameter int MIN_DUTY     = 32
) (
    input  logic                           clk_i,
    input  logic                           rstn_i,
    input  logic                           en_i,
    input  logic signed [ADC_BITWIDTH:0]   PID_value_i,
    output logic                           pwm_o,
    output logic                           period_strb_o,
    output logic        [ADC_BITWIDTH-1:0] duty_o,
    output logic        [1:0]              state_o
);

    localparam int W  = ADC_BITWIDTH;
    localparam int PW = (PRESCALER > 1) ? $clog2(PRESCALER) : 1;
    localparam int KW = (KICK_PERIODS > 1) ? $clog2(KICK_PERIODS) : 1;

    localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALER - 1);
    localparam logic [W-1:0]  CNT_LAST   = {{(W-1){1'b1}}, 1'b0};
    localparam logic [W-1:0]  DUTY_MAX   = {W{1'b1}};
    localparam logic [KW-1:0] KICK_INIT  = (KICK_PERIODS > 0) ? KW'(KICK_PERIODS - 1) : '0;

    typedef enum logic [1:0] {
        ST_OFF  = 2'd0,
        ST_KICK = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    logic [PW-1:0] presc_q, presc_d;
    logic [W-1:0]  cnt_q,   cnt_d;
    logic [KW-1:0] kick_q,  kick_d;
    logic          start_q, start_d;
    state_t        state_q, state_d;
    logic [W-1:0]  duty_q,  duty_d;
    logic          pwm_q,   pwm_d;
    logic          strb_q,  strb_d;

    logic          tick;
    logic          wrap;
    logic          boundary;
    logic          pid_pos;
    logic [W-1:0]  target_raw;
    logic [W-1:0]  target;

    // Negative or zero controller output means "fan off".
    assign pid_pos    = !PID_value_i[W] && (PID_value_i[W-1:0] != '0);
    assign target_raw = pid_pos ? PID_value_i[W-1:0] : '0;

`ifdef PWM_MIN_DUTY_EN
    localparam logic [W-1:0] MIN_D = W'(MIN_DUTY);
    assign target = ((target_raw != '0) && (target_raw < MIN_D)) ? MIN_D : target_raw;
`else
    logic [W-1:0] unused_min_duty;
    assign unused_min_duty = W'(MIN_DUTY);
    assign target          = target_raw;
`endif

    assign tick     = en_i && (presc_q == PRESC_LAST);
    assign wrap     = tick && (cnt_q == CNT_LAST);
    assign boundary = en_i && (start_q || wrap);

    always_comb begin
        presc_d = presc_q;
        cnt_d   = cnt_q;
        kick_d  = kick_q;
        start_d = start_q;
        state_d = state_q;
        duty_d  = duty_q;
        strb_d  = 1'b0;

        if (!en_i) begin
            presc_d = '0;
            cnt_d   = '0;
            kick_d  = '0;
            start_d = 1'b1;
            state_d = ST_OFF;
            duty_d  = '0;
        end else if (boundary) begin
            presc_d = '0;
            cnt_d   = '0;
            start_d = 1'b0;
            strb_d  = 1'b1;
            case (state_q)
                ST_OFF: begin
                    if (target != '0) begin
                        if (KICK_PERIODS > 0) begin
                            state_d = ST_KICK;
                            duty_d  = DUTY_MAX;
                            kick_d  = KICK_INIT;
                        end else begin
                            state_d = ST_RUN;
                            duty_d  = target;
                        end
                    end else begin
                        duty_d = '0;
                    end
                end
                ST_KICK: begin
                    if (target == '0) begin
                        state_d = ST_OFF;
                        duty_d  = '0;
                    end else if (kick_q == '0) begin
                        state_d = ST_RUN;
                        duty_d  = target;
                    end else begin
                        kick_d = kick_q - 1'b1;
                        duty_d = DUTY_MAX;
                    end
                end
                ST_RUN: begin
                    if (target == '0) begin
                        state_d = ST_OFF;
                        duty_d  = '0;
                    end else begin
                        duty_d = target;
                    end
                end
                default: begin
                    state_d = ST_OFF;
                    duty_d  = '0;
                end
            endcase
        end else if (tick) begin
            presc_d = '0;
            cnt_d   = cnt_q + 1'b1;
        end else begin
            presc_d = presc_q + 1'b1;
        end

        // Compare against the next count/duty so pwm_o rises with the strobe.
        pwm_d = en_i && (cnt_d < duty_d);
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            presc_q <= '0;
            cnt_q   <= '0;
            kick_q  <= '0;
            start_q <= 1'b1;
            state_q <= ST_OFF;
            duty_q  <= '0;
            pwm_q   <= 1'b0;
            strb_q  <= 1'b0;
        end else begin
            presc_q <= presc_d;
            cnt_q   <= cnt_d;
            kick_q  <= kick_d;
            start_q <= start_d;
            state_q <= state_d;
            duty_q  <= duty_d;
            pwm_q   <= pwm_d;
            strb_q  <= strb_d;
        end
    end

    assign pwm_o         = pwm_q;
    assign period_strb_o = strb_q;
    assign duty_o        = duty_q;
    assign state_o       = state_q;

endmodule
